// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  // Iterations per multiply/divide: one result bit per cycle.
  localparam int ITER = MULDIV_WIDTH;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIX   = 2'd2,
    WRITE = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_arith(input muldiv_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath shared by multiply and divide.
// Multiply: acc_lo starts as the multiplier, opnd holds the multiplicand; each step
//   conditionally adds into acc_hi and shifts {carry, acc_hi, acc_lo} right by one.
// Divide: acc_lo starts as the dividend, opnd holds the divisor; each step shifts
//   {acc_hi, acc_lo} left and does a restoring trial subtract; acc_hi ends as the
//   remainder and acc_lo as the quotient.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic [WIDTH-1:0] opnd;
  logic             div_mode;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic             rem_ge;

  // Next-step arithmetic for both modes; the register block picks one.
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    rem_ge  = (shifted >= {1'b0, opnd});
  end

  // Operand load on issue, then one iteration per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking so every register here samples the pre-edge values.
      acc_hi   <= '0;
      div_mode <= is_div;
      acc_lo   <= is_div ? opnd_a : opnd_b;
      opnd     <= is_div ? opnd_b : opnd_a;
    end else if (step) begin
      if (div_mode) begin
        // A remainder below the divisor fits WIDTH bits, so the wrapped subtract is exact.
        acc_hi <= rem_ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
      end else begin
        acc_hi <= add_sum[WIDTH:1];
        acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_controller.sv
// HI/LO write sequencer for the execute stage: iterative MULT/MULTU/DIV/DIVU plus
// single-cycle MTHI/MTLO, with a stall for MFHI/MFLO while a result is pending.
// Optional build macro DIVZERO_FLAG_EN: adds divZero; a DIV/DIVU by zero then skips
// the computation, pulses divZero one cycle after start and writes nothing.
module hilo_muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  muldiv_op_t            op,
  input  logic [WIDTH-1:0]      srcA,
  input  logic [WIDTH-1:0]      srcB,
  input  logic [WIDTH-1:0]      curHi,
  input  logic [WIDTH-1:0]      curLo,
  input  logic                  hiLoReadReq,
  output logic                  regHiLoWrite,
  output logic [1:0][WIDTH-1:0] hiLoData,
  output logic                  busy,
  output logic                  stall
`ifdef DIVZERO_FLAG_EN
  ,
  output logic                  divZero
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  muldiv_state_t    state;
  logic [CNT_W-1:0] count;
  logic             sign_a;
  logic             sign_b;
  logic             div_op;

  logic             div_by_zero;
  logic             issue_arith;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

`ifdef DIVZERO_FLAG_EN
  assign div_by_zero = op_is_div(op) && (srcB == '0);
`else
  // Without the flag a zero divisor runs the normal iteration.
  assign div_by_zero = 1'b0;
`endif

  assign issue_arith = (state == IDLE) && start && op_is_arith(op) && !div_by_zero;

  // Signed ops iterate on magnitudes; the most negative value maps to itself, which
  // is the correct unsigned magnitude.
  assign mag_a = (op_is_signed(op) && srcA[WIDTH-1]) ? -srcA : srcA;
  assign mag_b = (op_is_signed(op) && srcB[WIDTH-1]) ? -srcB : srcB;

  assign stall = hiLoReadReq & busy;

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (issue_arith),
    .step   (state == CALC),
    .is_div (op_is_div(op)),
    .opnd_a (mag_a),
    .opnd_b (mag_b),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  // Sign fix-up of the raw magnitude result; unsigned ops latch both signs as 0.
  // Both multiply and divide leave HI in acc_hi and LO in acc_lo.
  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (div_op) begin
      if (sign_a ^ sign_b) fix_lo = -acc_lo;
      if (sign_a)          fix_hi = -acc_hi;
    end else if (sign_a ^ sign_b) begin
      {fix_hi, fix_lo} = -{acc_hi, acc_lo};
    end
  end

  // Control FSM with registered write strobe, data and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      div_op       <= 1'b0;
      regHiLoWrite <= 1'b0;
      hiLoData     <= '0;
      busy         <= 1'b0;
`ifdef DIVZERO_FLAG_EN
      divZero      <= 1'b0;
`endif
    end else begin
      regHiLoWrite <= 1'b0;
`ifdef DIVZERO_FLAG_EN
      divZero      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            if (op == MTHI) begin
              regHiLoWrite <= 1'b1;
              hiLoData[0]  <= srcA;
              hiLoData[1]  <= curLo;
            end else if (op == MTLO) begin
              regHiLoWrite <= 1'b1;
              hiLoData[0]  <= curHi;
              hiLoData[1]  <= srcA;
`ifdef DIVZERO_FLAG_EN
            end else if (div_by_zero) begin
              divZero      <= 1'b1;
`endif
            end else if (op_is_arith(op)) begin
              state  <= CALC;
              busy   <= 1'b1;
              count  <= '0;
              sign_a <= op_is_signed(op) & srcA[WIDTH-1];
              sign_b <= op_is_signed(op) & srcB[WIDTH-1];
              div_op <= op_is_div(op);
            end
          end
        end
        CALC: begin
          if (count == LAST_ITER) begin
            count <= '0;
            state <= FIX;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        FIX: begin
          hiLoData[0]  <= fix_hi;
          hiLoData[1]  <= fix_lo;
          regHiLoWrite <= 1'b1;
          state        <= WRITE;
        end
        WRITE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// Directed testbench for hilo_muldiv_controller (WIDTH=32).
// Cycle numbering: the cycle in which start is driven is cycle 0; cycle k is the
// period following the k-th rising edge after that.
module tb_hilo_muldiv_controller;
  import muldiv_pkg::*;

  localparam int W = 32;
  // Rising edges from the edge that samples start to the write cycle (cycle W+2).
  localparam int LAT = W + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  muldiv_op_t           op;
  logic [W-1:0]         srcA;
  logic [W-1:0]         srcB;
  logic [W-1:0]         curHi;
  logic [W-1:0]         curLo;
  logic                 hiLoReadReq;
  logic                 regHiLoWrite;
  logic [1:0][W-1:0]    hiLoData;
  logic                 busy;
  logic                 stall;
`ifdef DIVZERO_FLAG_EN
  logic                 divZero;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hilo_muldiv_controller #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .srcA         (srcA),
    .srcB         (srcB),
    .curHi        (curHi),
    .curLo        (curLo),
    .hiLoReadReq  (hiLoReadReq),
    .regHiLoWrite (regHiLoWrite),
    .hiLoData     (hiLoData),
    .busy         (busy),
    .stall        (stall)
`ifdef DIVZERO_FLAG_EN
    ,
    .divZero      (divZero)
`endif
  );

  task automatic test_reset();
    reset       = 1'b1;
    start       = 1'b0;
    op          = MULT;
    srcA        = 32'h1111_1111;
    srcB        = 32'h2222_2222;
    curHi       = 32'h0;
    curLo       = 32'h0;
    hiLoReadReq = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (regHiLoWrite !== 1'b0) begin
      failures++;
      $display("FAIL reset_write: got %b expected 0", regHiLoWrite);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b expected 0", stall);
    end
    checks++;
    if (hiLoData !== 64'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", hiLoData);
    end
    @(negedge clk);
    reset       = 1'b0;
    hiLoReadReq = 1'b0;
  endtask

  task automatic run_arith(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input string name);
    int  lat;
    bit  seen;
    @(negedge clk);
    op    = o;
    srcA  = a;
    srcB  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: got %b expected 1", name, busy);
    end
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= LAT + 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (regHiLoWrite === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checks++;
    if (!seen || lat != LAT) begin
      failures++;
      $display("FAIL %s_latency: got seen=%0d edges=%0d expected edges=%0d", name, seen, lat, LAT);
    end
    checks++;
    if (hiLoData[0] !== exp_hi) begin
      failures++;
      $display("FAIL %s_hi: got %h expected %h", name, hiLoData[0], exp_hi);
    end
    checks++;
    if (hiLoData[1] !== exp_lo) begin
      failures++;
      $display("FAIL %s_lo: got %h expected %h", name, hiLoData[1], exp_lo);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regHiLoWrite !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_after: got write=%b busy=%b expected 0 0", name, regHiLoWrite, busy);
    end
  endtask

  task automatic test_arith();
    run_arith(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_arith(MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
    run_arith(MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_negneg");
    run_arith(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg_dividend");
    run_arith(DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_neg_divisor");
    run_arith(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu");
    run_arith(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow");
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    op    = MTHI;
    srcA  = 32'h0000_1234;
    curHi = 32'h0000_5555;
    curLo = 32'h0000_ABCD;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    curLo = 32'h0000_FFFF;
    checks++;
    if (regHiLoWrite !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi_strobe: got write=%b busy=%b expected 1 0", regHiLoWrite, busy);
    end
    checks++;
    if (hiLoData[0] !== 32'h0000_1234 || hiLoData[1] !== 32'h0000_ABCD) begin
      failures++;
      $display("FAIL mthi_data: got hi=%h lo=%h expected 00001234 0000abcd", hiLoData[0], hiLoData[1]);
    end
    @(negedge clk);
    op    = MTLO;
    srcA  = 32'h0000_5678;
    curHi = 32'h0000_9999;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (regHiLoWrite !== 1'b1 || hiLoData[0] !== 32'h0000_9999 || hiLoData[1] !== 32'h0000_5678) begin
      failures++;
      $display("FAIL mtlo: got write=%b hi=%h lo=%h expected 1 00009999 00005678",
               regHiLoWrite, hiLoData[0], hiLoData[1]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (regHiLoWrite !== 1'b0) begin
      failures++;
      $display("FAIL mtlo_pulse: got %b expected 0", regHiLoWrite);
    end
  endtask

  // MULTU issued at cycle 0, MFHI/MFLO from cycle 5, a second start at cycle 10.
  task automatic test_stall_and_ignore();
    int       stall_bad;
    int       writes;
    int       write_cycle;
    logic     exp_stall;
    logic [W-1:0] got_hi;
    logic [W-1:0] got_lo;
    stall_bad   = 0;
    writes      = 0;
    write_cycle = -1;
    got_hi      = '0;
    got_lo      = '0;
    @(negedge clk);
    op    = MULTU;
    srcA  = 32'hFFFF_FFFF;
    srcB  = 32'hFFFF_FFFF;
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      start = (k == 10);
      if (k == 10) begin
        op   = DIVU;
        srcA = 32'd100;
        srcB = 32'd7;
      end
      hiLoReadReq = (k >= 5);
      #1;
      exp_stall = (k >= 5 && k <= W + 2);
      if (stall !== exp_stall) stall_bad++;
      if (regHiLoWrite === 1'b1) begin
        writes++;
        write_cycle = k;
        got_hi      = hiLoData[0];
        got_lo      = hiLoData[1];
      end
    end
    hiLoReadReq = 1'b0;
    checks++;
    if (stall_bad != 0) begin
      failures++;
      $display("FAIL stall_window: got %0d wrong cycles expected 0", stall_bad);
    end
    checks++;
    if (writes != 1) begin
      failures++;
      $display("FAIL ignore_second_start: got %0d writes expected 1", writes);
    end
    checks++;
    if (write_cycle != W + 2) begin
      failures++;
      $display("FAIL write_cycle: got %0d expected %0d", write_cycle, W + 2);
    end
    checks++;
    if (got_hi !== 32'hFFFF_FFFE || got_lo !== 32'h0000_0001) begin
      failures++;
      $display("FAIL stall_result: got hi=%h lo=%h expected fffffffe 00000001", got_hi, got_lo);
    end
  endtask

  task automatic test_reset_abort();
    int writes;
    int busy_seen;
    writes    = 0;
    busy_seen = 0;
    @(negedge clk);
    op    = MULT;
    srcA  = 32'h0000_0005;
    srcB  = 32'h0000_0006;
    start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_before: got %b expected 1", busy);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || regHiLoWrite !== 1'b0) begin
      failures++;
      $display("FAIL abort_immediate: got busy=%b write=%b expected 0 0", busy, regHiLoWrite);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (regHiLoWrite === 1'b1) writes++;
      if (busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (writes != 0 || busy_seen != 0) begin
      failures++;
      $display("FAIL abort_no_write: got writes=%0d busy_cycles=%0d expected 0 0", writes, busy_seen);
    end
  endtask

  task automatic test_div_zero();
`ifdef DIVZERO_FLAG_EN
    int writes;
    int flag_extra;
    writes     = 0;
    flag_extra = 0;
    @(negedge clk);
    op    = DIVU;
    srcA  = 32'h0000_1234;
    srcB  = 32'h0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (divZero !== 1'b1 || busy !== 1'b0 || regHiLoWrite !== 1'b0) begin
      failures++;
      $display("FAIL divzero_pulse: got flag=%b busy=%b write=%b expected 1 0 0",
               divZero, busy, regHiLoWrite);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (regHiLoWrite === 1'b1) writes++;
      if (divZero !== 1'b0) flag_extra++;
    end
    checks++;
    if (writes != 0 || flag_extra != 0) begin
      failures++;
      $display("FAIL divzero_quiet: got writes=%0d flag_cycles=%0d expected 0 0", writes, flag_extra);
    end
`else
    run_arith(DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_zero");
`endif
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mthi_mtlo();
    test_stall_and_ignore();
    test_reset_abort();
    test_div_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
